bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255 (range 1..255): maximum number of cycles a bus transfer may wait for bus_ack_i before it is aborted.
REQ-002 Parameter DATA_FIRST, default 1: when 1, the data port wins simultaneous requests; when 0, the instruction port wins.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 if_ce_i  in  1  instruction fetch request.
REQ-006 if_addr_i  in  32  fetch address.
REQ-007 if_data_o  out  32  fetched instruction.
REQ-008 if_stallreq_o  out  1  fetch not yet complete; hold pipeline.
REQ-009 dm_ce_i  in  1  data access request.
REQ-010 dm_we_i  in  1  1 = write, 0 = read.
REQ-011 dm_addr_i  in  32  data address.
REQ-012 dm_sel_i  in  4  byte enables.
REQ-013 dm_data_i  in  32  write data.
REQ-014 dm_data_o  out  32  read data.
REQ-015 dm_stallreq_o  out  1  data access not yet complete.
REQ-016 bus_req_o  out  1  shared memory transfer request.
REQ-017 bus_we_o  out  1  shared memory write enable.
REQ-018 bus_addr_o  out  32  shared memory address.
REQ-019 bus_sel_o  out  4  shared memory byte enables.
REQ-020 bus_wdata_o  out  32  shared memory write data.
REQ-021 bus_rdata_i  in  32  shared memory read data; valid when bus_ack_i=1.
REQ-022 bus_ack_i  in  1  transfer complete (single-cycle pulse).
REQ-023 bus_err_o  out  1  one-cycle pulse on timeout abort.

Function
REQ-024 The FSM SHALL have states IDLE, IF_WAIT, DM_WAIT, IF_DONE and DM_DONE.
REQ-025 IDLE: if no ce_i is high, remain in IDLE; otherwise grant per DATA_FIRST, latch address, sel (instruction port uses 4'b1111), we (instruction port uses 0) and wdata into the bus_* registers, clear the timeout counter, and go to the matching WAIT state.
REQ-026 bus_req_o SHALL be 1 exactly in IF_WAIT and DM_WAIT. bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o SHALL be registered and stable throughout a WAIT state.
REQ-027 WAIT with bus_ack_i=1: capture bus_rdata_i into the owner's read-data register (a write captures 32'h0) and go to the matching DONE state.
REQ-028 WAIT with bus_ack_i=0: increment the 8-bit counter; when the counter equals TIMEOUT-1, capture 32'h0, pulse bus_err_o on the next cycle, and go to DONE.
REQ-029 A DONE state SHALL last exactly 1 cycle, then return to IDLE; the request is re-evaluated in IDLE on the following cycle.
REQ-030 if_stallreq_o = if_ce_i AND state != IF_DONE; dm_stallreq_o = dm_ce_i AND state != DM_DONE (combinational).
REQ-031 if_data_o and dm_data_o SHALL be driven from their capture registers and hold value until the next capture.
REQ-032 Minimum latency SHALL be request in IDLE at cycle 0, bus_req_o at cycle 1, ack at cycle 1, stallreq low at cycle 2.
REQ-033 The losing requester SHALL keep its stallreq high until it is itself granted and completes; no requester is granted twice in a row while the other is pending (after DONE, the other port wins the next IDLE arbitration).
REQ-034 A bus_ack_i arriving in IDLE or DONE SHALL be ignored.
REQ-035 A ce_i deasserted during WAIT SHALL NOT abort the transfer; the transfer completes normally.

Reset
REQ-036 While rst=0, the block SHALL force state to IDLE, set all outputs and capture registers to 0, and clear the counter, including when reset asserts mid-transfer.
REQ-037 The first grant after rst rises SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-038 Instruction read: if_ce_i=1, if_addr_i=32'h100, ack 3 cycles after bus_req_o with rdata 32'h3C010001 -> bus_addr_o=32'h100, bus_sel_o=4'hF, bus_we_o=0; if_data_o=32'h3C010001; if_stallreq_o low for 1 cycle.
REQ-039 Simultaneous requests, DATA_FIRST=1: dm write addr 32'h200, sel 4'b0011, data 32'h1234 with if_ce_i=1 -> data transfer first with bus_we_o=1, then fetch; if_stallreq_o stays high until fetch done.
REQ-040 Fairness: dm_ce_i and if_ce_i held high continuously -> grants alternate DM, IF, DM, IF.
REQ-041 Timeout: TIMEOUT=4, no ack -> bus_req_o high 4 cycles, bus_err_o pulses once, dm_data_o=0, dm_stallreq_o drops for 1 cycle.
REQ-042 Reset mid-transfer: rst=0 during DM_WAIT -> bus_req_o=0 immediately; after release, a pending request is re-granted from IDLE.
REQ-043 Spurious ack: bus_ack_i=1 in IDLE with no ce_i -> no state change and no output change.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the arbiter, its two requesting ports (fetch and data)
// and the shared memory. The arbiter takes the master view; the CPU/memory side takes the slave view.
interface bus_arbiter_if;
   logic        if_ce_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_stallreq_o;

   logic        dm_ce_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [3:0]  dm_sel_i;
   logic [31:0] dm_data_i;
   logic [31:0] dm_data_o;
   logic        dm_stallreq_o;

   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i;
   logic        bus_ack_i;
   logic        bus_err_o;

   modport master (
      input  if_ce_i, if_addr_i,
      input  dm_ce_i, dm_we_i, dm_addr_i, dm_sel_i, dm_data_i,
      input  bus_rdata_i, bus_ack_i,
      output if_data_o, if_stallreq_o,
      output dm_data_o, dm_stallreq_o,
      output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o
   );

   modport slave (
      output if_ce_i, if_addr_i,
      output dm_ce_i, dm_we_i, dm_addr_i, dm_sel_i, dm_data_i,
      output bus_rdata_i, bus_ack_i,
      input  if_data_o, if_stallreq_o,
      input  dm_data_o, dm_stallreq_o,
      input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, bus_err_o
   );
endinterface

// File: rtl/bus_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one shared memory bus,
// alternating ownership under contention and aborting transfers that never see an ack.
module bus_arbiter #(
   parameter int unsigned TIMEOUT    = 255,
   parameter bit          DATA_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.master bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_WAIT = 3'd1,
      DM_WAIT = 3'd2,
      IF_DONE = 3'd3,
      DM_DONE = 3'd4
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state, w_state_next;
   logic [7:0]  r_cnt, w_cnt_next;
   logic        r_bus_we, w_bus_we_next;
   logic [31:0] r_bus_addr, w_bus_addr_next;
   logic [3:0]  r_bus_sel, w_bus_sel_next;
   logic [31:0] r_bus_wdata, w_bus_wdata_next;
   logic [31:0] r_if_data, w_if_data_next;
   logic [31:0] r_dm_data, w_dm_data_next;
   logic        r_err, w_err_next;
   logic        r_after_done, w_after_done_next;
   logic        r_last_dm, w_last_dm_next;
   logic        w_grant_dm;
   logic        w_timeout;

   // r_after_done/r_last_dm remember who finished in the immediately preceding
   // cycle, so contention right after a transfer goes to the other port.
   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_bus_we_next     = r_bus_we;
      w_bus_addr_next   = r_bus_addr;
      w_bus_sel_next    = r_bus_sel;
      w_bus_wdata_next  = r_bus_wdata;
      w_if_data_next    = r_if_data;
      w_dm_data_next    = r_dm_data;
      w_err_next        = 1'b0;
      w_after_done_next = 1'b0;
      w_last_dm_next    = r_last_dm;
      w_grant_dm        = 1'b0;
      w_timeout         = (r_cnt == CNT_LAST);

      case (r_state)
         IDLE: begin
            if (bus.dm_ce_i && bus.if_ce_i) begin
               w_grant_dm = r_after_done ? !r_last_dm : DATA_FIRST;
            end else begin
               w_grant_dm = bus.dm_ce_i;
            end
            if (bus.dm_ce_i || bus.if_ce_i) begin
               w_cnt_next = 8'd0;
               if (w_grant_dm) begin
                  w_state_next     = DM_WAIT;
                  w_bus_we_next    = bus.dm_we_i;
                  w_bus_addr_next  = bus.dm_addr_i;
                  w_bus_sel_next   = bus.dm_sel_i;
                  w_bus_wdata_next = bus.dm_data_i;
               end else begin
                  w_state_next     = IF_WAIT;
                  w_bus_we_next    = 1'b0;
                  w_bus_addr_next  = bus.if_addr_i;
                  w_bus_sel_next   = 4'b1111;
                  w_bus_wdata_next = 32'h0;
               end
            end
         end

         IF_WAIT: begin
            if (bus.bus_ack_i) begin
               w_if_data_next = bus.bus_rdata_i;
               w_state_next   = IF_DONE;
            end else if (w_timeout) begin
               w_if_data_next = 32'h0;
               w_err_next     = 1'b1;
               w_state_next   = IF_DONE;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end

         DM_WAIT: begin
            if (bus.bus_ack_i) begin
               w_dm_data_next = r_bus_we ? 32'h0 : bus.bus_rdata_i;
               w_state_next   = DM_DONE;
            end else if (w_timeout) begin
               w_dm_data_next = 32'h0;
               w_err_next     = 1'b1;
               w_state_next   = DM_DONE;
            end else begin
               w_cnt_next = r_cnt + 8'd1;
            end
         end

         IF_DONE: begin
            w_state_next      = IDLE;
            w_after_done_next = 1'b1;
            w_last_dm_next    = 1'b0;
         end

         DM_DONE: begin
            w_state_next      = IDLE;
            w_after_done_next = 1'b1;
            w_last_dm_next    = 1'b1;
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_cnt        <= 8'd0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= 32'h0;
         r_bus_sel    <= 4'h0;
         r_bus_wdata  <= 32'h0;
         r_if_data    <= 32'h0;
         r_dm_data    <= 32'h0;
         r_err        <= 1'b0;
         r_after_done <= 1'b0;
         r_last_dm    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_bus_we     <= w_bus_we_next;
         r_bus_addr   <= w_bus_addr_next;
         r_bus_sel    <= w_bus_sel_next;
         r_bus_wdata  <= w_bus_wdata_next;
         r_if_data    <= w_if_data_next;
         r_dm_data    <= w_dm_data_next;
         r_err        <= w_err_next;
         r_after_done <= w_after_done_next;
         r_last_dm    <= w_last_dm_next;
      end
   end

   assign bus.bus_req_o     = (r_state == IF_WAIT) || (r_state == DM_WAIT);
   assign bus.bus_we_o      = r_bus_we;
   assign bus.bus_addr_o    = r_bus_addr;
   assign bus.bus_sel_o     = r_bus_sel;
   assign bus.bus_wdata_o   = r_bus_wdata;
   assign bus.bus_err_o     = r_err;
   assign bus.if_data_o     = r_if_data;
   assign bus.dm_data_o     = r_dm_data;
   assign bus.if_stallreq_o = bus.if_ce_i && (r_state != IF_DONE);
   assign bus.dm_stallreq_o = bus.dm_ce_i && (r_state != DM_DONE);
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a transaction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_bus_arbiter;
   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   chk_en = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   err_pulses = 0;

   bus_arbiter_if bif();

   bus_arbiter #(.TIMEOUT(TIMEOUT), .DATA_FIRST(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bif.bus_req_o) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: bus_req_o got 0 within 20 cycles, required 1", tag);
      end
   endtask

   // Model: ports numbered 1 = fetch, 2 = data; 0 = nobody.
   int          m_own = 0, m_done = 0, m_last = 0, m_waited = 0;
   logic        m_we = 1'b0, m_err = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_if_data = '0, m_dm_data = '0;
   logic [3:0]  m_sel = '0;

   function automatic int pick(input logic ic, input logic dc, input int last);
      if (ic && dc) return (last != 0) ? 3 - last : 2;
      return dc ? 2 : 1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_own <= 0; m_done <= 0; m_last <= 0; m_waited <= 0;
         m_we <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0;
         m_sel <= '0; m_if_data <= '0; m_dm_data <= '0;
      end else begin
         m_err  <= 1'b0;
         m_last <= 0;
         if (m_own != 0) begin
            if (bif.bus_ack_i || m_waited == TIMEOUT - 1) begin
               if (m_own == 1) m_if_data <= bif.bus_ack_i ? bif.bus_rdata_i : 32'h0;
               else            m_dm_data <= (bif.bus_ack_i && !m_we) ? bif.bus_rdata_i : 32'h0;
               m_err  <= !bif.bus_ack_i;
               m_done <= m_own;
               m_own  <= 0;
            end else begin
               m_waited <= m_waited + 1;
            end
         end else if (m_done != 0) begin
            m_last <= m_done;
            m_done <= 0;
         end else if (bif.if_ce_i || bif.dm_ce_i) begin
            m_waited <= 0;
            if (pick(bif.if_ce_i, bif.dm_ce_i, m_last) == 2) begin
               m_own <= 2; m_we <= bif.dm_we_i; m_addr <= bif.dm_addr_i;
               m_sel <= bif.dm_sel_i; m_wdata <= bif.dm_data_i;
            end else begin
               m_own <= 1; m_we <= 1'b0; m_addr <= bif.if_addr_i;
               m_sel <= 4'hF; m_wdata <= 32'h0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("bus_req_o", 32'(bif.bus_req_o), 32'(m_own != 0));
         chk("bus_we_o", 32'(bif.bus_we_o), 32'(m_we));
         chk("bus_addr_o", bif.bus_addr_o, m_addr);
         chk("bus_sel_o", 32'(bif.bus_sel_o), 32'(m_sel));
         if (m_own == 2) chk("bus_wdata_o", bif.bus_wdata_o, m_wdata);
         chk("bus_err_o", 32'(bif.bus_err_o), 32'(m_err));
         chk("if_data_o", bif.if_data_o, m_if_data);
         chk("dm_data_o", bif.dm_data_o, m_dm_data);
         chk("if_stallreq_o", 32'(bif.if_stallreq_o), 32'(bif.if_ce_i && m_done != 1));
         chk("dm_stallreq_o", 32'(bif.dm_stallreq_o), 32'(bif.dm_ce_i && m_done != 2));
         if (bif.bus_err_o) err_pulses++;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   logic [31:0] grants [4];
   logic [31:0] grants_exp [4];
   int          n_req;

   initial begin
      bif.if_ce_i = 1'b0; bif.if_addr_i = '0;
      bif.dm_ce_i = 1'b0; bif.dm_we_i = 1'b0; bif.dm_addr_i = '0;
      bif.dm_sel_i = '0;  bif.dm_data_i = '0;
      bif.bus_rdata_i = '0; bif.bus_ack_i = 1'b0;
      #2 rst = 1'b0;
      chk_en = 1'b1;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      chk("reset bus_req_o", 32'(bif.bus_req_o), 32'h0);
      chk("reset if_data_o", bif.if_data_o, 32'h0);
      chk("reset bus_addr_o", bif.bus_addr_o, 32'h0);
      $display("[%0t] reset released", $time);

      // Instruction read, ack on the 4th request cycle (last count before timeout)
      bif.if_ce_i = 1'b1; bif.if_addr_i = 32'h100;
      cyc(1);
      wait_req("t1 fetch");
      chk("t1 bus_addr_o", bif.bus_addr_o, 32'h100);
      chk("t1 bus_sel_o", 32'(bif.bus_sel_o), 32'hF);
      chk("t1 bus_we_o", 32'(bif.bus_we_o), 32'h0);
      cyc(3);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h3C010001;
      cyc(1);
      bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0;
      chk("t1 if_data_o", bif.if_data_o, 32'h3C010001);
      chk("t1 if_stallreq_o done", 32'(bif.if_stallreq_o), 32'h0);
      cyc(1);
      chk("t1 if_stallreq_o after", 32'(bif.if_stallreq_o), 32'h1);
      bif.if_ce_i = 1'b0;
      $display("[%0t] T1 instruction read: if_data_o=%h", $time, bif.if_data_o);

      // Spurious ack while idle
      cyc(1);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hDEADBEEF;
      cyc(1);
      bif.bus_ack_i = 1'b0; bif.bus_rdata_i = '0;
      cyc(1);
      chk("t2 if_data_o held", bif.if_data_o, 32'h3C010001);
      chk("t2 dm_data_o held", bif.dm_data_o, 32'h0);
      chk("t2 bus_req_o", 32'(bif.bus_req_o), 32'h0);
      $display("[%0t] T2 spurious ack ignored", $time);

      // Fairness under continuous contention
      bif.dm_ce_i = 1'b1; bif.dm_we_i = 1'b0; bif.dm_addr_i = 32'h300; bif.dm_sel_i = 4'hF;
      bif.if_ce_i = 1'b1; bif.if_addr_i = 32'h400;
      cyc(1);
      for (int g = 0; g < 4; g++) begin
         wait_req("t4 grant");
         grants[g] = bif.bus_addr_o;
         bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hA5000000 + bif.bus_addr_o;
         cyc(1);
         bif.bus_ack_i = 1'b0;
         $display("[%0t] T4 grant %0d to address %h", $time, g, grants[g]);
      end
      bif.dm_ce_i = 1'b0; bif.if_ce_i = 1'b0;
      cyc(1);
      grants_exp[0] = 32'h300; grants_exp[1] = 32'h400;
      grants_exp[2] = 32'h300; grants_exp[3] = 32'h400;
      for (int g = 0; g < 4; g++) chk("t4 grant order", grants[g], grants_exp[g]);
      chk("t4 dm_data_o", bif.dm_data_o, 32'hA5000300);
      chk("t4 if_data_o", bif.if_data_o, 32'hA5000400);

      // Simultaneous write + fetch, data port first
      bif.dm_ce_i = 1'b1; bif.dm_we_i = 1'b1; bif.dm_addr_i = 32'h200;
      bif.dm_sel_i = 4'b0011; bif.dm_data_i = 32'h1234;
      bif.if_ce_i = 1'b1; bif.if_addr_i = 32'h104;
      cyc(1);
      chk("t3 bus_req_o", 32'(bif.bus_req_o), 32'h1);
      chk("t3 bus_we_o", 32'(bif.bus_we_o), 32'h1);
      chk("t3 bus_addr_o", bif.bus_addr_o, 32'h200);
      chk("t3 bus_sel_o", 32'(bif.bus_sel_o), 32'h3);
      chk("t3 bus_wdata_o", bif.bus_wdata_o, 32'h1234);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hFFFFFFFF;
      cyc(1);
      bif.bus_ack_i = 1'b0;
      chk("t3 dm_data_o write", bif.dm_data_o, 32'h0);
      chk("t3 dm_stallreq_o", 32'(bif.dm_stallreq_o), 32'h0);
      chk("t3 if_stallreq_o", 32'(bif.if_stallreq_o), 32'h1);
      bif.dm_ce_i = 1'b0; bif.dm_we_i = 1'b0;
      wait_req("t3 fetch");
      chk("t3 fetch bus_addr_o", bif.bus_addr_o, 32'h104);
      chk("t3 fetch bus_we_o", 32'(bif.bus_we_o), 32'h0);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'hAABBCCDD;
      cyc(1);
      bif.bus_ack_i = 1'b0;
      chk("t3 if_data_o", bif.if_data_o, 32'hAABBCCDD);
      chk("t3 if_stallreq_o done", 32'(bif.if_stallreq_o), 32'h0);
      bif.if_ce_i = 1'b0;
      cyc(1);
      $display("[%0t] T3 write then fetch complete", $time);

      // Reset in the middle of a data transfer
      bif.dm_ce_i = 1'b1; bif.dm_addr_i = 32'h600; bif.dm_sel_i = 4'hF;
      cyc(1);
      wait_req("t6 first");
      cyc(1);
      rst = 1'b0;
      #1;
      chk("t6 bus_req_o in reset", 32'(bif.bus_req_o), 32'h0);
      chk("t6 if_data_o in reset", bif.if_data_o, 32'h0);
      chk("t6 bus_addr_o in reset", bif.bus_addr_o, 32'h0);
      cyc(2);
      rst = 1'b1;
      chk("t6 bus_req_o before edge", 32'(bif.bus_req_o), 32'h0);
      cyc(1);
      chk("t6 regrant bus_req_o", 32'(bif.bus_req_o), 32'h1);
      chk("t6 regrant bus_addr_o", bif.bus_addr_o, 32'h600);
      bif.bus_ack_i = 1'b1; bif.bus_rdata_i = 32'h600D600D;
      cyc(1);
      bif.bus_ack_i = 1'b0;
      chk("t6 dm_data_o", bif.dm_data_o, 32'h600D600D);
      bif.dm_ce_i = 1'b0;
      cyc(1);
      $display("[%0t] T6 reset mid-transfer and re-grant", $time);

      // Timeout with no ack
      bif.dm_ce_i = 1'b1; bif.dm_addr_i = 32'h500;
      cyc(1);
      wait_req("t5 timeout");
      n_req = 0;
      for (int i = 0; i < 10 && bif.bus_req_o; i++) begin
         n_req++;
         cyc(1);
      end
      chk("t5 bus_req_o cycles", 32'(n_req), 32'd4);
      chk("t5 bus_err_o", 32'(bif.bus_err_o), 32'h1);
      chk("t5 dm_data_o", bif.dm_data_o, 32'h0);
      chk("t5 dm_stallreq_o", 32'(bif.dm_stallreq_o), 32'h0);
      bif.dm_ce_i = 1'b0;
      cyc(1);
      chk("t5 bus_err_o after", 32'(bif.bus_err_o), 32'h0);
      cyc(2);
      chk("err pulse count", 32'(err_pulses), 32'd1);
      $display("[%0t] T5 timeout abort", $time);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
